// File: rtl/vram_scanout.sv
// VGA-timed scanout of the 512x256 Hack screen buffer through a 2-stage fetch/pixel pipeline.
// Optional macro SCANOUT_FRAMECNT_EN adds a 16-bit frame_count output.
module vram_scanout #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned X_OFF     = 64,
  parameter int unsigned Y_OFF     = 112,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vram_loaded,
  output logic [13:0] vram_raddr,
  input  logic [15:0] vram_data,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        pixel,
`ifdef SCANOUT_FRAMECNT_EN
  output logic [15:0] frame_count,
`endif
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned WIN_W   = 512;
  localparam int unsigned WIN_H   = 256;

  typedef enum logic {
    WAIT_LOAD = 1'b0,
    RUN       = 1'b1
  } state_e;

  state_e        r_state;
  state_e        w_state_nxt;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [31:0]   w_h32;
  logic [31:0]   w_v32;
  logic          w_h_last;
  logic          w_v_last;
  logic          w_run;
  logic [8:0]    w_cx;
  logic [7:0]    w_cy;
  logic          w_in_win;
  logic          w_fetch;

  logic          r_s1_de;
  logic          r_s1_hs;
  logic          r_s1_vs;
  logic          r_s1_win;
  logic          r_s1_fetch;
  logic          r_s1_fs;
  logic [3:0]    r_s1_cx;
  logic [15:0]   r_word;
  logic [15:0]   w_word;

  // Stage 0: beam position decode
  assign w_h32    = 32'(r_h);
  assign w_v32    = 32'(r_v);
  assign w_h_last = (w_h32 == H_TOTAL - 1);
  assign w_v_last = (w_v32 == V_TOTAL - 1);
  assign w_run    = (r_state == RUN);
  assign w_cx     = 9'(w_h32 - X_OFF);
  assign w_cy     = 8'(w_v32 - Y_OFF);
  assign w_in_win = (w_h32 < H_ACTIVE) && (w_v32 < V_ACTIVE) &&
                    (w_h32 >= X_OFF) && (w_h32 < X_OFF + WIN_W) &&
                    (w_v32 >= Y_OFF) && (w_v32 < Y_OFF + WIN_H);
  assign w_fetch  = w_in_win && w_run && (w_cx[3:0] == 4'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_h_last) begin
      r_h <= '0;
      r_v <= w_v_last ? '0 : r_v + VW'(1);
    end else begin
      r_h <= r_h + HW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= WAIT_LOAD;
    else          r_state <= w_state_nxt;
  end

  // Display only starts on a whole-frame boundary; RUN is left only via reset
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT_LOAD: if (w_h_last && w_v_last && vram_loaded) w_state_nxt = RUN;
      RUN:       w_state_nxt = RUN;
      default:   w_state_nxt = WAIT_LOAD;
    endcase
  end

  // Stage 0 -> 1: issue fetch and carry timing alongside the read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vram_raddr <= '0;
      r_s1_de    <= 1'b0;
      r_s1_hs    <= 1'b1;
      r_s1_vs    <= 1'b1;
      r_s1_win   <= 1'b0;
      r_s1_fetch <= 1'b0;
      r_s1_fs    <= 1'b0;
      r_s1_cx    <= '0;
    end else begin
      r_s1_de    <= (w_h32 < H_ACTIVE) && (w_v32 < V_ACTIVE);
      r_s1_hs    <= !((w_h32 >= H_ACTIVE + H_FP) && (w_h32 < H_ACTIVE + H_FP + H_SYNC));
      r_s1_vs    <= !((w_v32 >= V_ACTIVE + V_FP) && (w_v32 < V_ACTIVE + V_FP + V_SYNC));
      r_s1_win   <= w_in_win && w_run;
      r_s1_fetch <= w_fetch;
      r_s1_fs    <= (r_h == '0) && (r_v == '0);
      r_s1_cx    <= w_cx[3:0];
      if (w_fetch) vram_raddr <= 14'(BASE_ADDR + 32'({w_cy, w_cx[8:4]}));
    end
  end

  // Fresh word is used directly on its first pixel, then held for the other 15
  assign w_word = r_s1_fetch ? vram_data : r_word;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_word      <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      pixel       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (r_s1_fetch) r_word <= vram_data;
      hsync       <= r_s1_hs;
      vsync       <= r_s1_vs;
      de          <= r_s1_de;
      pixel       <= w_word[r_s1_cx] & r_s1_win;
      frame_start <= r_s1_fs;
    end
  end

`ifdef SCANOUT_FRAMECNT_EN
  logic r_s1_run;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_run    <= 1'b0;
      frame_count <= '0;
    end else begin
      r_s1_run <= w_run;
      if (r_s1_fs && r_s1_run) frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vram_scanout.sv
// Directed bench for vram_scanout on a shrunken raster (540x10 total, window clipped to 4 rows).
module tb_vram_scanout;

  localparam int unsigned H_ACTIVE  = 520;
  localparam int unsigned H_FP      = 4;
  localparam int unsigned H_SYNC    = 8;
  localparam int unsigned H_BP      = 8;
  localparam int unsigned V_ACTIVE  = 6;
  localparam int unsigned V_FP      = 1;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BP      = 1;
  localparam int unsigned X_OFF     = 4;
  localparam int unsigned Y_OFF     = 2;
  localparam int unsigned BASE_ADDR = 16352;
  localparam int HT = 540;
  localparam int FR = 5400;

  logic        clk;
  logic        reset_n;
  logic        vram_loaded;
  logic [13:0] vram_raddr;
  logic [15:0] vram_data;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic        pixel;
  logic        frame_start;
`ifdef SCANOUT_FRAMECNT_EN
  logic [15:0] frame_count;
`endif

  int n_cmp;
  int n_err;
  int edges;

  vram_scanout #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .X_OFF(X_OFF), .Y_OFF(Y_OFF), .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .vram_loaded(vram_loaded),
    .vram_raddr(vram_raddr),
    .vram_data(vram_data),
    .hsync(hsync),
    .vsync(vsync),
    .de(de),
    .pixel(pixel),
`ifdef SCANOUT_FRAMECNT_EN
    .frame_count(frame_count),
`endif
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRAM image: row0 w0=0001 (wraps to 16352), row0 w31=8001, row1 w0=0010, row3 w1=8001
  always_comb begin
    case (vram_raddr)
      14'd16352: vram_data = 16'h0001;
      14'd16383: vram_data = 16'h8001;
      14'd0:     vram_data = 16'h0010;
      14'd65:    vram_data = 16'h8001;
      default:   vram_data = 16'h0000;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at edge %0d: got %0h, wanted %0h", tag, edges, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, 32'(obs), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    edges++;
    #1;
  endtask

  task automatic goto(input int e);
    while (edges < e) tick();
  endtask

  function automatic logic is_black(input int h, input int v);
    return (v == 2 && (h == 4 || h == 500 || h == 515)) ||
           (v == 3 && h == 8) ||
           (v == 5 && (h == 20 || h == 35));
  endfunction

  initial begin
    int c;
    int h;
    int v;
    int n_chg;
    logic [13:0] prev;
    n_cmp = 0;
    n_err = 0;
    edges = 0;
    n_chg = 0;
    reset_n = 1'b0;
    vram_loaded = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    chk1("rst_hsync", hsync, 1'b1);
    chk1("rst_vsync", vsync, 1'b1);
    chk1("rst_de", de, 1'b0);
    chk1("rst_pixel", pixel, 1'b0);
    chk1("rst_fstart", frame_start, 1'b0);
    chk("rst_raddr", 32'(vram_raddr), 32'd0);
`ifdef SCANOUT_FRAMECNT_EN
    chk("rst_fcount", 32'(frame_count), 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    edges = 0;

    // Frame 0: blank while waiting for load; load arrives mid-frame
    for (int e = 1; e <= FR + 1; e++) begin
      tick();
      if (e == 2000) vram_loaded = 1'b1;
      chk1("f0_pixel", pixel, 1'b0);
      chk("f0_raddr", 32'(vram_raddr), 32'd0);
      if (e == 1)    chk1("f0_hs_e1", hsync, 1'b1);
      if (e == 1)    chk1("f0_de_e1", de, 1'b0);
      if (e == 2)    chk1("f0_fstart", frame_start, 1'b1);
      if (e == 2)    chk1("f0_de_first", de, 1'b1);
      if (e == 3)    chk1("f0_fstart_end", frame_start, 1'b0);
      if (e == 522)  chk1("f0_de_off", de, 1'b0);
      if (e == 525)  chk1("f0_hs_pre", hsync, 1'b1);
      if (e == 526)  chk1("f0_hs_fall", hsync, 1'b0);
      if (e == 533)  chk1("f0_hs_last", hsync, 1'b0);
      if (e == 534)  chk1("f0_hs_rise", hsync, 1'b1);
      if (e == 3781) chk1("f0_vs_pre", vsync, 1'b1);
      if (e == 3782) chk1("f0_vs_fall", vsync, 1'b0);
      if (e == 4861) chk1("f0_vs_last", vsync, 1'b0);
      if (e == 4862) chk1("f0_vs_rise", vsync, 1'b1);
`ifdef SCANOUT_FRAMECNT_EN
      if (e == 2)    chk("f0_fcount", 32'(frame_count), 32'd0);
`endif
    end

    // Frame 1: first displayed frame, full raster sweep
    prev = vram_raddr;
    for (int e = FR + 2; e <= 2 * FR + 1; e++) begin
      tick();
      c = e - FR - 2;
      h = c % HT;
      v = c / HT;
      chk1("f1_pixel", pixel, is_black(h, v));
      chk1("f1_de", de, (h < 520) && (v < 6));
      chk1("f1_hsync", hsync, !((h >= 524) && (h < 532)));
      chk1("f1_vsync", vsync, !((v >= 7) && (v < 9)));
      chk1("f1_fstart", frame_start, c == 0);
      if (vram_raddr != prev) n_chg++;
      prev = vram_raddr;
      if (e == 6484) chk("f1_raddr_pre", 32'(vram_raddr), 32'd0);
      if (e == 6485) chk("f1_raddr_r0w0", 32'(vram_raddr), 32'd16352);
      if (e == 6980) chk("f1_raddr_r0w30", 32'(vram_raddr), 32'd16382);
      if (e == 6981) chk("f1_raddr_r0w31", 32'(vram_raddr), 32'd16383);
      if (e == 7024) chk("f1_raddr_hold", 32'(vram_raddr), 32'd16383);
      if (e == 7025) chk("f1_raddr_wrap", 32'(vram_raddr), 32'd0);
      if (e == 7041) chk("f1_raddr_r1w1", 32'(vram_raddr), 32'd1);
      if (e == 8601) chk("f1_raddr_r3w31", 32'(vram_raddr), 32'd95);
`ifdef SCANOUT_FRAMECNT_EN
      if (e == FR + 2) chk("f1_fcount", 32'(frame_count), 32'd1);
`endif
    end
    chk("f1_raddr_changes", 32'(n_chg), 32'd128);

    // Frame 2: load deasserted, display must continue
    goto(2 * FR + 2);
    vram_loaded = 1'b0;
    chk1("f2_fstart", frame_start, 1'b1);
`ifdef SCANOUT_FRAMECNT_EN
    chk("f2_fcount", 32'(frame_count), 32'd2);
`endif
    goto(11885);
    chk("f2_raddr_r0w0", 32'(vram_raddr), 32'd16352);
    goto(11886);
    chk1("f2_pix_4_2", pixel, 1'b1);
    goto(11887);
    chk1("f2_pix_5_2", pixel, 1'b0);
    goto(12430);
    chk1("f2_pix_8_3", pixel, 1'b1);
    goto(3 * FR + 2);
    chk1("f3_fstart", frame_start, 1'b1);
`ifdef SCANOUT_FRAMECNT_EN
    chk("f3_fcount", 32'(frame_count), 32'd3);
`endif

    // Reset mid-line at h=300, v=3 of frame 3
    goto(18120);
    chk1("mid_de_pre", de, 1'b1);
    chk("mid_raddr_pre", 32'(vram_raddr), 32'd18);
    reset_n = 1'b0;
    #1;
    chk1("mid_hsync", hsync, 1'b1);
    chk1("mid_vsync", vsync, 1'b1);
    chk1("mid_de", de, 1'b0);
    chk1("mid_pixel", pixel, 1'b0);
    chk1("mid_fstart", frame_start, 1'b0);
    chk("mid_raddr", 32'(vram_raddr), 32'd0);
`ifdef SCANOUT_FRAMECNT_EN
    chk("mid_fcount", 32'(frame_count), 32'd0);
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    vram_loaded = 1'b1;
    edges = 0;

    for (int e = 1; e <= FR + 1; e++) begin
      tick();
      chk1("r0_pixel", pixel, 1'b0);
      chk("r0_raddr", 32'(vram_raddr), 32'd0);
`ifdef SCANOUT_FRAMECNT_EN
      if (e == 2) chk("r0_fcount", 32'(frame_count), 32'd0);
`endif
    end
    goto(FR + 2);
    chk1("r1_fstart", frame_start, 1'b1);
`ifdef SCANOUT_FRAMECNT_EN
    chk("r1_fcount", 32'(frame_count), 32'd1);
`endif
    goto(6485);
    chk("r1_raddr_r0w0", 32'(vram_raddr), 32'd16352);
    goto(6486);
    chk1("r1_pix_4_2", pixel, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vram_scanout.md
Name: vram_scanout

Overview:
- Downstream consumer of the VRAM read port.
- Generates display timing (640x480@60 VGA by default) and walks the 512x256 Hack screen buffer: 32 words per row, bit 0 of each word is the leftmost pixel.
- Issues vram_raddr, absorbs the 1-cycle SPRAM read latency, and emits a registered monochrome pixel stream with hsync/vsync/de, the screen centred in the active area.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- X_OFF, 64, first active column of the screen window
- Y_OFF, 112, first active line of the screen window
- BASE_ADDR, 0, VRAM word address of screen row 0, word 0

Ports:
- clk  in  1  system clock, one pixel per cycle
- reset_n  in  1  asynchronous, active-low reset
- vram_loaded  in  1  VRAM load complete
- vram_raddr  out  14  VRAM read address
- vram_data  in  16  VRAM read data; valid the cycle after vram_raddr
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- de  out  1  display enable, high in the 640x480 active area
- pixel  out  1  1 = black (Hack convention); 0 outside the window or before load
- frame_start  out  1  1-cycle pulse aligned with output of pixel (0,0)

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - h=0, v=0, state=WAIT_LOAD.
  - Outputs: hsync=1, vsync=1, de=0, pixel=0, frame_start=0, vram_raddr=0.
- Counters:
  - h runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - v increments when h wraps, and runs 0..V_TOTAL-1 (525).
  - Both wrap to 0.
- Stage 0, cycle t:
  - Compute cx = h - X_OFF and cy = v - Y_OFF.
  - in_win = h,v active && 0<=cx<512 && 0<=cy<256.
  - When in_win and cx[3:0]==0: vram_raddr <= BASE_ADDR + cy*32 + cx[8:4], 14-bit with wrap.
  - vram_raddr otherwise holds its last value.
- Stage 1, cycle t+1:
  - vram_data is valid.
  - Latch it into the word register when the delayed cx[3:0]==0.
- Stage 2, cycle t+2:
  - Registered outputs: pixel = word[cx mod 16] & in_win & running.
  - hsync, vsync and de are those of counter value t, delayed 2 cycles.
  - Total latency is exactly 2 cycles, uniform for all outputs.
- Sync windows:
  - hsync low for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync likewise using the V_* parameters.
- FSM:
  - WAIT_LOAD: timing runs; pixel forced 0; vram_raddr held 0.
  - WAIT_LOAD -> RUN at the cycle where h==H_TOTAL-1, v==V_TOTAL-1 and vram_loaded==1. Display begins on a whole-frame boundary.
  - RUN is sticky; a later vram_loaded deassertion is ignored.
  - Only reset_n returns the FSM to WAIT_LOAD.
- frame_start: pulses in stage 2 for h==0, v==0, every frame, in either state.
- Boundaries:
  - Last word of a row is fetched at cx=496.
  - Row 255 word 31 is address BASE_ADDR+8191.
  - No fetch outside the window.
  - A reset mid-line zeroes all pipeline registers immediately; no stale pixel is emitted after release.

Optional Feature:
- Macro: SCANOUT_FRAMECNT_EN.
- Defined:
  - Adds output port frame_count, 16 bits.
  - Resets to 0 and increments by 1, wrapping at 0xFFFF, in the same cycle frame_start is asserted.
  - Counts only in RUN.
- Undefined: the port and counter are absent.
- All other behaviour is identical in both builds.

Test Plan:
- Reset check:
  - Stimulus: hold reset_n=0 for 5 cycles, release.
  - Required: hsync=1, vsync=1, de=0, pixel=0, vram_raddr=0 during reset.
  - Required: first hsync falling edge 2+656 cycles after release.
  - Required: vsync low on lines 490-491.
- Address sequence:
  - Stimulus: vram_loaded=1 from reset.
  - Required: in frame 2, line v=112 issues raddr 0,1,...,31 at h=64,80,...,560.
  - Required: line v=367 issues 8160..8191.
  - Required: no other addresses change.
- Pixel alignment:
  - Stimulus: model VRAM returns 0x0001 at addr 0 and 0x8000 at addr 31.
  - Required: pixel=1 exactly at output cycles for (h=64,v=112) and (h=575,v=112).
  - Required: all other pixels 0.
  - Required: de=1 across h=0..639.
- Load gating:
  - Stimulus: vram_loaded rises mid-frame 0.
  - Required: pixel stays 0 for the rest of frame 0.
  - Required: display begins at frame 1 with frame_start aligned to the first output.
  - Stimulus: vram_loaded later drops.
  - Required: output unaffected.
- Reset mid-line:
  - Stimulus: assert reset_n=0 at h=300, v=200 in RUN.
  - Required: outputs return to reset values the same cycle.
  - Required: after release, WAIT_LOAD is re-entered and one blank frame precedes display.
- Frame counter (SCANOUT_FRAMECNT_EN):
  - Required: frame_count=0 after reset.
  - Required: increments once per frame_start in RUN; reaches 3 after 3 RUN frames.
